// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Round-robin arbiter sharing one register-file read port
//               among four requesters; three-cycle IDLE/ADDR/RESP handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [11:0]      req_addr,
    output logic [2:0]       ra,
    input  logic [WIDTH-1:0] rd_data,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_winner;
    logic [1:0]       w_winner_nxt;
    logic [2:0]       w_ra_nxt;
    logic [3:0]       w_ack_nxt;
    logic [WIDTH-1:0] w_rdata_nxt;
    logic [1:0]       w_pick;

    // Scan from the farthest candidate back toward ptr so the nearest set
    // request at or above ptr (with wrap) is the last one written.
    always_comb begin
        w_pick = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_pick = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_winner_nxt = r_winner;
        w_ra_nxt     = ra;
        w_ack_nxt    = ack;
        w_rdata_nxt  = rdata;
        case (r_state)
            S_IDLE: begin
                w_ack_nxt = 4'b0000;
                if (|req) begin
                    w_winner_nxt = w_pick;
                    w_ra_nxt     = req_addr[3*w_pick +: 3];
                    w_state_nxt  = S_ADDR;
                end
            end
            S_ADDR: begin
                w_rdata_nxt = rd_data;
                w_ack_nxt   = 4'b0001 << r_winner;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_ack_nxt   = 4'b0000;
                w_ptr_nxt   = r_winner + 2'd1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                // Unreachable encoding: recover silently, never strobe ack.
                w_ack_nxt   = 4'b0000;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_winner <= 2'd0;
            ra       <= 3'd0;
            ack      <= 4'b0000;
            rdata    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_winner <= w_winner_nxt;
            ra       <= w_ra_nxt;
            ack      <= w_ack_nxt;
            rdata    <= w_rdata_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the register data width (matches the register-file read-port width).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port req, input, 4 bits: read request per requester 0..3.
REQ-005 The block SHALL have the port req_addr, input, 12 bits: requester i's register address in bits [3i+2:3i].
REQ-006 The block SHALL have the port ra, output, 3 bits: registered read-address select to the 8-entry register-file read mux.
REQ-007 The block SHALL have the port rd_data, input, WIDTH bits: combinational read-mux output for address ra.
REQ-008 The block SHALL have the port ack, output, 4 bits: registered one-hot completion strobe per requester.
REQ-009 The block SHALL have the port rdata, output, WIDTH bits: registered read result, valid while ack is nonzero.
REQ-010 The block SHALL have the port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, ADDR, RESP.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE and hold ra, rdata and ptr.
REQ-013 In IDLE with req!=0, the block SHALL select as winner the first set req bit found searching upward from ptr with wrap 3->0, latch the winner id, load ra with that requester's req_addr field, and go to ADDR.
REQ-014 In ADDR, the block SHALL load rdata from rd_data, set ack to one-hot(winner), and go to RESP.
REQ-015 In RESP, the block SHALL clear ack to 0 at the next edge, set ptr to (winner+1) mod 4, and go to IDLE.
REQ-016 The block SHALL hold ack high for exactly one cycle per transaction, with exactly one bit set.
REQ-017 Latency SHALL be fixed: req sampled at edge E0, then ack and rdata valid during the cycle after edge E1, cleared at edge E2; throughput is one grant per 3 cycles.
REQ-018 The block SHALL hold ra constant from ADDR entry through RESP; changes to req_addr after sampling SHALL NOT affect the transaction.
REQ-019 Deassertion of the winner's req after sampling SHALL NOT abort the transaction; ack still pulses.
REQ-020 The block SHALL sample req only in IDLE; a request still asserted in IDLE after its ack SHALL be treated as a new request and arbitrated against others.
REQ-021 With all four requesters continuously asserting req, the block SHALL grant in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4), starving none.
REQ-022 The block SHALL hold rdata after ack falls until the next ADDR state.
REQ-023 Unused, illegal FSM encodings SHALL return to IDLE on the next edge without asserting ack.

Reset
REQ-024 While rst_n is low, regardless of clk, the block SHALL force state=IDLE, ptr=0, ra=0, ack=0, rdata=0, busy=0.
REQ-025 On reset assertion mid-transaction (ADDR or RESP), the block SHALL abort the transaction, produce no ack, and restart arbitration from ptr=0 after release.
REQ-026 On rst_n release, the block SHALL respond normally from the first rising edge of clk.

Verification
REQ-027 Reset check: assert rst_n=0 mid-ADDR -> ra=0, ack=0, rdata=0, busy=0 immediately, without waiting for a clock edge.
REQ-028 Single request: req=4'b0100, req_addr field 2 = 5, register 5 = 4'hA -> ra=5 after E0; ack=4'b0100 and rdata=4'hA after E1; ack=0 after E2.
REQ-029 Round robin: req=4'b1111 held, ptr=0 after reset -> acks in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
REQ-030 Wrap search: ptr=3 and req=4'b0011 -> requester 0 wins, then ptr=1.
REQ-031 Stability: change req_addr and drop req during ADDR -> ra is unchanged; ack still pulses with the originally addressed data.
REQ-032 Back-to-back: a requester keeps req high after its ack while requester 2 also requests -> requester 2 is granted next.
